// File: rtl/sent_tx_frame_gen.sv
// sent_tx_frame_gen
// SENT (SAE J2716) fast-channel transmitter. Generates the whole line
// waveform from a latched status nibble and NUM_NIBBLES data nibbles:
// sync, status, data, CRC and an optional pause pulse.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   enable        allow new frames to be accepted
//   frame_valid   status/data inputs are valid
//   frame_ready   a frame is accepted this cycle when frame_valid is high
//   status_nibble status/communication nibble
//   data_nibbles  data nibbles, MS nibble transmitted first
//   sent_out      SENT line, idles high
//   busy          a frame is on the line
//   frame_done    one-cycle pulse on the last line cycle of each frame
//   crc_out       CRC of the most recently accepted frame
//   overrun       constant-frame-length mode: frame did not fit FRAME_TICKS
//
// All line outputs are registered from the state/counter registers, so
// they lag the FSM by one clock: an accept at edge k puts the sync low
// phase on the line at edge k+1, and frame_ready (combinational, in the
// FSM's final cycle) leads the registered frame_done by that same clock.
module sent_tx_frame_gen #(
    parameter int NUM_NIBBLES = 6,
    parameter int TICK_DIV    = 4,
    parameter int LOW_TICKS   = 5,
    parameter int PAUSE_MODE  = 0,
    parameter int PAUSE_TICKS = 12,
    parameter int FRAME_TICKS = 300
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic [3:0]               status_nibble,
    input  logic [4*NUM_NIBBLES-1:0] data_nibbles,
    output logic                     sent_out,
    output logic                     busy,
    output logic                     frame_done,
    output logic [3:0]               crc_out,
    output logic                     overrun
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_STATUS = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC    = 3'd4,
        ST_PAUSE  = 3'd5
    } state_t;

    localparam int          DW         = 4 * NUM_NIBBLES;
    localparam logic [7:0]  DIV_LAST   = 8'(TICK_DIV - 1);
    localparam logic [11:0] LOW_LEN    = 12'(LOW_TICKS);
    localparam logic [2:0]  NIB_LAST   = 3'(NUM_NIBBLES - 1);
    localparam logic [4:0]  SHIFT_MS   = 5'(4 * (NUM_NIBBLES - 1));
    localparam logic [11:0] PAUSE_LEN  = 12'(PAUSE_TICKS);
    localparam logic [11:0] FRAME_LEN  = 12'(FRAME_TICKS);
    // Sync plus the 12-tick base of status, every data nibble and CRC.
    localparam logic [11:0] FIXED_USED = 12'(56 + 12 * (NUM_NIBBLES + 2));

    // SAE J2716 CRC lookup for poly x^4+x^3+x^2+1.
    function automatic logic [3:0] crc_table(input logic [3:0] idx);
        logic [3:0] val;
        case (idx)
            4'd0:    val = 4'd0;
            4'd1:    val = 4'd13;
            4'd2:    val = 4'd7;
            4'd3:    val = 4'd10;
            4'd4:    val = 4'd14;
            4'd5:    val = 4'd3;
            4'd6:    val = 4'd9;
            4'd7:    val = 4'd4;
            4'd8:    val = 4'd1;
            4'd9:    val = 4'd12;
            4'd10:   val = 4'd6;
            4'd11:   val = 4'd11;
            4'd12:   val = 4'd15;
            4'd13:   val = 4'd2;
            4'd14:   val = 4'd8;
            4'd15:   val = 4'd5;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    // Seeded table CRC over the data nibbles (status excluded), MS first,
    // followed by one augmentation step with a zero nibble.
    function automatic logic [3:0] calc_crc(input logic [DW-1:0] data);
        logic [3:0] crc;
        crc = 4'h5;
        for (int i = NUM_NIBBLES - 1; i >= 0; i--) begin
            crc = crc_table(crc) ^ data[4*i +: 4];
        end
        return crc_table(crc);
    endfunction

    state_t          state_r, state_nx_s;
    logic [7:0]      div_cnt_r, div_cnt_nx_s;
    logic [11:0]     tick_cnt_r, tick_cnt_nx_s;
    logic [2:0]      nib_idx_r, nib_idx_nx_s;

    logic [3:0]      status_r;
    logic [DW-1:0]   data_r;
    logic [3:0]      crc_r;
    logic [11:0]     pause_len_r;
    logic            ovr_flag_r;

    logic            sent_r;
    logic            busy_r;
    logic            done_r;
    logic            overrun_r;

    logic [DW-1:0]   data_sh_s;
    logic [3:0]      cur_nib_s;
    logic [11:0]     pulse_len_s;
    logic            pulse_end_s;
    logic            final_pulse_s;
    logic            frame_ready_s;
    logic            accept_s;

    logic [3:0]      crc_in_s;
    logic [11:0]     used_in_s;
    logic [11:0]     pause_in_s;
    logic            ovr_in_s;

    // Current pulse length, end-of-pulse detection and the accept handshake.
    always_comb begin
        data_sh_s = data_r >> (SHIFT_MS - {nib_idx_r, 2'b00});
        cur_nib_s = data_sh_s[3:0];
        case (state_r)
            ST_SYNC:   pulse_len_s = 12'd56;
            ST_STATUS: pulse_len_s = 12'd12 + {8'd0, status_r};
            ST_DATA:   pulse_len_s = 12'd12 + {8'd0, cur_nib_s};
            ST_CRC:    pulse_len_s = 12'd12 + {8'd0, crc_r};
            ST_PAUSE:  pulse_len_s = pause_len_r;
            default:   pulse_len_s = 12'd1;
        endcase
        pulse_end_s = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST) &&
                      (tick_cnt_r == pulse_len_s - 12'd1);
        if (PAUSE_MODE == 32'sd0) begin
            final_pulse_s = (state_r == ST_CRC);
        end else begin
            final_pulse_s = (state_r == ST_PAUSE);
        end
        frame_ready_s = enable && ((state_r == ST_IDLE) || (final_pulse_s && pulse_end_s));
        accept_s      = frame_valid && frame_ready_s;
    end

    // CRC and pause length of the incoming frame, captured on accept so the
    // CRC is visible the cycle after acceptance.
    always_comb begin
        crc_in_s   = calc_crc(data_nibbles);
        used_in_s  = FIXED_USED + {8'd0, status_nibble} + {8'd0, crc_in_s};
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            used_in_s = used_in_s + {8'd0, data_nibbles[4*i +: 4]};
        end
        pause_in_s = PAUSE_LEN;
        ovr_in_s   = 1'b0;
        if (PAUSE_MODE == 32'sd2) begin
            // Widened compare: the pause must still be at least 12 ticks.
            if ({1'b0, FRAME_LEN} >= ({1'b0, used_in_s} + 13'd12)) begin
                pause_in_s = FRAME_LEN - used_in_s;
            end else begin
                pause_in_s = 12'd12;
                ovr_in_s   = 1'b1;
            end
        end else begin
            pause_in_s = PAUSE_LEN;
        end
    end

    // Next-state and counter logic of the pulse sequencer.
    always_comb begin
        state_nx_s    = state_r;
        div_cnt_nx_s  = div_cnt_r;
        tick_cnt_nx_s = tick_cnt_r;
        nib_idx_nx_s  = nib_idx_r;
        if (state_r == ST_IDLE) begin
            div_cnt_nx_s  = 8'd0;
            tick_cnt_nx_s = 12'd0;
            nib_idx_nx_s  = 3'd0;
            if (accept_s) begin
                state_nx_s = ST_SYNC;
            end else begin
                state_nx_s = ST_IDLE;
            end
        end else if (div_cnt_r != DIV_LAST) begin
            div_cnt_nx_s = div_cnt_r + 8'd1;
        end else if (!pulse_end_s) begin
            div_cnt_nx_s  = 8'd0;
            tick_cnt_nx_s = tick_cnt_r + 12'd1;
        end else begin
            div_cnt_nx_s  = 8'd0;
            tick_cnt_nx_s = 12'd0;
            case (state_r)
                ST_SYNC:   state_nx_s = ST_STATUS;
                ST_STATUS: begin
                    state_nx_s   = ST_DATA;
                    nib_idx_nx_s = 3'd0;
                end
                ST_DATA: begin
                    if (nib_idx_r == NIB_LAST) begin
                        state_nx_s = ST_CRC;
                    end else begin
                        state_nx_s   = ST_DATA;
                        nib_idx_nx_s = nib_idx_r + 3'd1;
                    end
                end
                ST_CRC: begin
                    if (PAUSE_MODE != 32'sd0) begin
                        state_nx_s = ST_PAUSE;
                    end else if (accept_s) begin
                        state_nx_s = ST_SYNC;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (accept_s) begin
                        state_nx_s = ST_SYNC;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                default:   state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State and prescaler/tick/nibble counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= 8'd0;
            tick_cnt_r <= 12'd0;
            nib_idx_r  <= 3'd0;
        end else begin
            state_r    <= state_nx_s;
            div_cnt_r  <= div_cnt_nx_s;
            tick_cnt_r <= tick_cnt_nx_s;
            nib_idx_r  <= nib_idx_nx_s;
        end
    end

    // Frame contents latched on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_r    <= 4'd0;
            data_r      <= '0;
            crc_r       <= 4'd0;
            pause_len_r <= 12'd12;
            ovr_flag_r  <= 1'b0;
        end else if (accept_s) begin
            status_r    <= status_nibble;
            data_r      <= data_nibbles;
            crc_r       <= crc_in_s;
            pause_len_r <= pause_in_s;
            ovr_flag_r  <= ovr_in_s;
        end
    end

    // Registered line and status outputs, one clock behind the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_r    <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            sent_r    <= (state_r == ST_IDLE) ? 1'b1 : (tick_cnt_r >= LOW_LEN);
            busy_r    <= (state_r != ST_IDLE);
            done_r    <= final_pulse_s && pulse_end_s;
            overrun_r <= final_pulse_s && pulse_end_s && ovr_flag_r;
        end
    end

    assign frame_ready = frame_ready_s;
    assign sent_out    = sent_r;
    assign busy        = busy_r;
    assign frame_done  = done_r;
    assign crc_out     = crc_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Self-checking bench for sent_tx_frame_gen. Four instances with different
// parameter sets share clock, reset and the status/data bus; each has its
// own enable and frame_valid. Expected line waveforms are built from the
// pulse-length rules (tick lengths times TICK_DIV) and compared cycle by cycle.
module tb_sent_tx_frame_gen;

    localparam int P_NUM  [4] = '{6, 3, 6, 6};
    localparam int P_DIV  [4] = '{2, 1, 1, 1};
    localparam int P_LOW  [4] = '{5, 4, 5, 5};
    localparam int P_MODE [4] = '{0, 1, 2, 2};
    localparam int P_PT   [4] = '{12, 20, 12, 12};
    localparam int P_FT   [4] = '{300, 300, 300, 200};

    int crc_tab [16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};

    logic        clk;
    logic        reset;
    logic [3:0]  en;
    logic [3:0]  valid;
    logic [3:0]  status;
    logic [23:0] data;
    logic [3:0]  ready_w;
    logic [3:0]  sent_w;
    logic [3:0]  busy_w;
    logic [3:0]  done_w;
    logic [3:0]  ovr_w;
    logic [3:0]  crc_w [4];

    int n_cmp;
    int n_bad;

    sent_tx_frame_gen #(.NUM_NIBBLES(P_NUM[0]), .TICK_DIV(P_DIV[0]), .LOW_TICKS(P_LOW[0]),
                        .PAUSE_MODE(P_MODE[0]), .PAUSE_TICKS(P_PT[0]), .FRAME_TICKS(P_FT[0])) u_dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .frame_valid(valid[0]), .frame_ready(ready_w[0]),
        .status_nibble(status), .data_nibbles(data), .sent_out(sent_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0]), .crc_out(crc_w[0]), .overrun(ovr_w[0]));

    sent_tx_frame_gen #(.NUM_NIBBLES(P_NUM[1]), .TICK_DIV(P_DIV[1]), .LOW_TICKS(P_LOW[1]),
                        .PAUSE_MODE(P_MODE[1]), .PAUSE_TICKS(P_PT[1]), .FRAME_TICKS(P_FT[1])) u_dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .frame_valid(valid[1]), .frame_ready(ready_w[1]),
        .status_nibble(status), .data_nibbles(data[11:0]), .sent_out(sent_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1]), .crc_out(crc_w[1]), .overrun(ovr_w[1]));

    sent_tx_frame_gen #(.NUM_NIBBLES(P_NUM[2]), .TICK_DIV(P_DIV[2]), .LOW_TICKS(P_LOW[2]),
                        .PAUSE_MODE(P_MODE[2]), .PAUSE_TICKS(P_PT[2]), .FRAME_TICKS(P_FT[2])) u_dut2 (
        .clk(clk), .reset(reset), .enable(en[2]), .frame_valid(valid[2]), .frame_ready(ready_w[2]),
        .status_nibble(status), .data_nibbles(data), .sent_out(sent_w[2]), .busy(busy_w[2]),
        .frame_done(done_w[2]), .crc_out(crc_w[2]), .overrun(ovr_w[2]));

    sent_tx_frame_gen #(.NUM_NIBBLES(P_NUM[3]), .TICK_DIV(P_DIV[3]), .LOW_TICKS(P_LOW[3]),
                        .PAUSE_MODE(P_MODE[3]), .PAUSE_TICKS(P_PT[3]), .FRAME_TICKS(P_FT[3])) u_dut3 (
        .clk(clk), .reset(reset), .enable(en[3]), .frame_valid(valid[3]), .frame_ready(ready_w[3]),
        .status_nibble(status), .data_nibbles(data), .sent_out(sent_w[3]), .busy(busy_w[3]),
        .frame_done(done_w[3]), .crc_out(crc_w[3]), .overrun(ovr_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC: seed 5, data nibbles MS first, one augmentation step.
    function automatic int model_crc(input int n, input logic [23:0] d);
        int c;
        c = 5;
        for (int i = n - 1; i >= 0; i--) c = crc_tab[c] ^ int'(d[4*i +: 4]);
        return crc_tab[c];
    endfunction

    // Expected line bits (one per clock) of a single frame.
    task automatic model_frame(input int idx, input logic [3:0] st, input logic [23:0] d,
                               output bit bits[$], output bit ovr);
        int lens[$];
        int used;
        int p;
        int div;
        int low;
        div = P_DIV[idx];
        low = P_LOW[idx];
        bits.delete();
        lens.push_back(56);
        lens.push_back(12 + int'(st));
        for (int i = P_NUM[idx] - 1; i >= 0; i--) lens.push_back(12 + int'(d[4*i +: 4]));
        lens.push_back(12 + model_crc(P_NUM[idx], d));
        ovr = 1'b0;
        if (P_MODE[idx] == 1) begin
            lens.push_back(P_PT[idx]);
        end else if (P_MODE[idx] == 2) begin
            used = 0;
            foreach (lens[k]) used += lens[k];
            p = P_FT[idx] - used;
            if (p < 12) begin
                p = 12;
                ovr = 1'b1;
            end
            lens.push_back(p);
        end
        foreach (lens[k]) begin
            for (int c = 0; c < lens[k] * div; c++) bits.push_back(c >= low * div);
        end
    endtask

    // Presents frames in order, checks frame_ready timing and crc_out.
    task automatic drive(input int idx, input logic [3:0] sts[$], input logic [23:0] dts[$],
                         input int waits[$], input string name);
        int w;
        int exp_crc;
        for (int f = 0; f < sts.size(); f++) begin
            status = sts[f];
            data = dts[f];
            valid[idx] = 1'b1;
            w = 0;
            while (ready_w[idx] !== 1'b1 && w < 4000) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (w != waits[f]) begin
                n_bad++;
                $display("FAIL %s_ready_f%0d: frame_ready after %0d cycles, expected %0d", name, f, w, waits[f]);
            end
            if (ready_w[idx] !== 1'b1) begin
                valid[idx] = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            exp_crc = model_crc(P_NUM[idx], dts[f]);
            n_cmp++;
            if (crc_w[idx] !== 4'(exp_crc)) begin
                n_bad++;
                $display("FAIL %s_crc_f%0d: crc_out=%0d expected %0d", name, f, crc_w[idx], exp_crc);
            end
        end
        valid[idx] = 1'b0;
    endtask

    // Captures the line from the first falling edge and compares it.
    task automatic monitor(input int idx, input bit eb[$], input int ends[$], input bit ovrs[$],
                           input string name);
        int waited;
        int first_bad;
        bit bad_val;
        int busy_low;
        int done_bad;
        int ovr_bad;
        int post_bad;
        int fi;
        bit exp_done;
        bit exp_ovr;
        waited = 0;
        @(negedge clk);
        while (sent_w[idx] !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (sent_w[idx] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_start: sent_out=%b after %0d cycles, expected falling edge to 0", name, sent_w[idx], waited);
            return;
        end
        first_bad = -1;
        bad_val = 1'b0;
        busy_low = 0;
        done_bad = 0;
        ovr_bad = 0;
        fi = 0;
        for (int i = 0; i < eb.size(); i++) begin
            exp_done = (fi < ends.size()) && (i == ends[fi]);
            exp_ovr = exp_done && ovrs[fi];
            if (sent_w[idx] !== eb[i] && first_bad < 0) begin
                first_bad = i;
                bad_val = sent_w[idx];
            end
            if (busy_w[idx] !== 1'b1) busy_low++;
            if (done_w[idx] !== exp_done) done_bad++;
            if (ovr_w[idx] !== exp_ovr) ovr_bad++;
            if (exp_done) fi++;
            @(negedge clk);
        end
        n_cmp++;
        if (first_bad >= 0) begin
            n_bad++;
            $display("FAIL %s_wave: sent_out=%b at cycle %0d, expected %b", name, bad_val, first_bad, eb[first_bad]);
        end
        n_cmp++;
        if (busy_low != 0) begin
            n_bad++;
            $display("FAIL %s_busy: busy low in %0d frame cycles, expected 0", name, busy_low);
        end
        n_cmp++;
        if (done_bad != 0) begin
            n_bad++;
            $display("FAIL %s_done: frame_done wrong in %0d cycles, expected 0 (ends at %0d)", name, done_bad, ends[ends.size()-1]);
        end
        n_cmp++;
        if (ovr_bad != 0) begin
            n_bad++;
            $display("FAIL %s_overrun: overrun wrong in %0d cycles, expected 0", name, ovr_bad);
        end
        post_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (sent_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0 || done_w[idx] !== 1'b0) post_bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (post_bad != 0) begin
            n_bad++;
            $display("FAIL %s_idle_after: %0d bad idle cycles, expected 0", name, post_bad);
        end
    endtask

    task automatic run_case(input int idx, input logic [3:0] sts[$], input logic [23:0] dts[$],
                            input string name);
        bit eb[$];
        bit fb[$];
        int ends[$];
        bit ovrs[$];
        int waits[$];
        bit o;
        int last_len;
        last_len = 0;
        for (int f = 0; f < sts.size(); f++) begin
            model_frame(idx, sts[f], dts[f], fb, o);
            waits.push_back((f == 0) ? 0 : last_len - 1);
            last_len = fb.size();
            foreach (fb[i]) eb.push_back(fb[i]);
            ends.push_back(eb.size() - 1);
            ovrs.push_back(o);
        end
        fork
            drive(idx, sts, dts, waits, name);
            monitor(idx, eb, ends, ovrs, name);
        join
    endtask

    function automatic logic [23:0] rand_data(input int idx);
        logic [23:0] d;
        d = 24'($urandom);
        if (P_NUM[idx] == 3) d = d & 24'h000FFF;
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en = 4'hF;
        valid = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({sent_w[i], busy_w[i], done_w[i], ovr_w[i], crc_w[i], ready_w[i]} !== 9'b1_0_0_0_0000_1) begin
                n_bad++;
                $display("FAIL reset_state_%0d: {sent,busy,done,ovr,crc,ready}=%b expected 100000001", i,
                         {sent_w[i], busy_w[i], done_w[i], ovr_w[i], crc_w[i], ready_w[i]});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_plan_frames();
        logic [3:0]  sts[$];
        logic [23:0] dts[$];
        sts.push_back(4'h0);
        dts.push_back(24'h000000);
        run_case(0, sts, dts, "plan_zero");
        sts.delete();
        dts.delete();
        sts.push_back(4'($urandom));
        dts.push_back(24'h000123);
        run_case(1, sts, dts, "plan_123");
    endtask

    task automatic test_random_frames();
        logic [3:0]  sts[$];
        logic [23:0] dts[$];
        for (int r = 0; r < 4; r++) begin
            sts.delete();
            dts.delete();
            sts.push_back(4'($urandom));
            dts.push_back(rand_data(r % 2));
            run_case(r % 2, sts, dts, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sts[$];
        logic [23:0] dts[$];
        for (int idx = 0; idx < 2; idx++) begin
            sts.delete();
            dts.delete();
            for (int f = 0; f < 3; f++) begin
                sts.push_back(4'($urandom));
                dts.push_back(rand_data(idx));
            end
            run_case(idx, sts, dts, "b2b");
        end
    endtask

    task automatic test_const_frame();
        logic [3:0]  sts[$];
        logic [23:0] dts[$];
        sts.push_back(4'hF);
        dts.push_back(24'hFFFFFF);
        run_case(2, sts, dts, "cfl_300");
        run_case(3, sts, dts, "cfl_200_ovr");
        for (int idx = 2; idx < 4; idx++) begin
            sts.delete();
            dts.delete();
            for (int f = 0; f < 2; f++) begin
                sts.push_back(4'($urandom));
                dts.push_back(rand_data(idx));
            end
            run_case(idx, sts, dts, "cfl_rand");
        end
    endtask

    task automatic test_reset_mid();
        status = 4'h0;
        data = 24'h000000;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (180) @(negedge clk);
        n_cmp++;
        if (busy_w[0] !== 1'b1 || crc_w[0] !== 4'd5) begin
            n_bad++;
            $display("FAIL rst_mid_pre: busy=%b crc_out=%0d expected busy=1 crc_out=5", busy_w[0], crc_w[0]);
        end
        en[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({sent_w[0], busy_w[0], crc_w[0], ready_w[0]} !== 7'b1_0_0000_1) begin
            n_bad++;
            $display("FAIL rst_mid_out: {sent,busy,crc,ready}=%b expected 1000001",
                     {sent_w[0], busy_w[0], crc_w[0], ready_w[0]});
        end
        n_cmp++;
        if (ready_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_ready_dis: frame_ready=%b with enable low, expected 0", ready_w[1]);
        end
        reset = 1'b0;
        en[1] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        bit eb[$];
        int ends[$];
        bit ovrs[$];
        bit o;
        logic [3:0] st;
        logic [23:0] d;
        int rdy_hi;
        int sent_low;
        st = 4'($urandom);
        d = rand_data(0);
        model_frame(0, st, d, eb, o);
        ends.push_back(eb.size() - 1);
        ovrs.push_back(o);
        rdy_hi = 0;
        fork
            begin
                status = st;
                data = d;
                valid[0] = 1'b1;
                n_cmp++;
                if (ready_w[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL en_drop_accept: frame_ready=%b expected 1", ready_w[0]);
                end
                @(posedge clk);
                @(negedge clk);
                n_cmp++;
                if (crc_w[0] !== 4'(model_crc(6, d))) begin
                    n_bad++;
                    $display("FAIL en_drop_crc: crc_out=%0d expected %0d", crc_w[0], model_crc(6, d));
                end
                data = rand_data(0);
                status = 4'($urandom);
                repeat (170 + $urandom_range(0, 90)) @(negedge clk);
                en[0] = 1'b0;
                for (int i = 0; i < 600; i++) begin
                    if (ready_w[0] !== 1'b0) rdy_hi++;
                    @(negedge clk);
                end
                n_cmp++;
                if (rdy_hi != 0) begin
                    n_bad++;
                    $display("FAIL en_drop_ready: frame_ready high %0d cycles after enable drop, expected 0", rdy_hi);
                end
            end
            monitor(0, eb, ends, ovrs, "en_drop");
        join
        sent_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (sent_w[0] !== 1'b1) sent_low++;
            @(negedge clk);
        end
        n_cmp++;
        if (sent_low != 0) begin
            n_bad++;
            $display("FAIL en_drop_line_idle: sent_out low %0d cycles, expected 0", sent_low);
        end
        valid[0] = 1'b0;
        en[0] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        en = 4'hF;
        valid = 4'h0;
        status = 4'h0;
        data = 24'h000000;
        @(negedge clk);
        test_reset();
        test_plan_frames();
        test_random_frames();
        test_back_to_back();
        test_const_frame();
        test_reset_mid();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
